mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares one downstream memory port between the icache refill port (rd_req/ret_*) and the data sram port (req/addrok/dataok).
// - Sits between mycpu_core and the AXI bridge; exactly one transaction is outstanding at a time.
// - Data requests have priority; instruction refills are guarded against starvation when MEM_ARB_FAIR_EN is defined.
// PARAMETERS
// - LINE_WORDS    4  beats per icache line refill (inst_rd_type==3'b100); power of two, 2..16
// - STARVE_LIMIT  8  consecutive data grants allowed while an inst request waits (MEM_ARB_FAIR_EN only); 1..255
// PORTS
// - clk             in   1   clock
// - resetn          in   1   asynchronous active-low reset
// - inst_rd_req     in   1   icache refill request
// - inst_rd_type    in   3   3'b100 = line refill, any other value = single word
// - inst_rd_addr    in  32   refill address
// - inst_rd_rdy     out  1   refill request accepted this cycle
// - inst_ret_valid  out  1   refill beat valid
// - inst_ret_last   out  1   last refill beat
// - inst_ret_data   out 32   refill beat data
// - data_req / data_wr   in   1 / 1    data request / write flag
// - data_size / data_wstrb  in  3 / 4    access size / byte strobes
// - data_addr / data_wdata  in  32 / 32  address / write data
// - data_addrok     out  1   data request accepted this cycle
// - data_dataok     out  1   read data valid or write completed
// - data_rdata      out 32   read data
// - mem_req / mem_wr     out  1 / 1    downstream request / write flag
// - mem_len         out  8   beats-1 (LINE_WORDS-1 for line refill, else 0)
// - mem_size / mem_wstrb    out  3 / 4    size / strobes (wstrb 0 for reads)
// - mem_addr / mem_wdata    out 32 / 32
// - mem_addr_ok     in   1   downstream accepted request
// - mem_rvalid / mem_rlast  in  1 / 1    read beat valid / last beat
// - mem_rdata       in  32   read beat data
// - mem_bvalid      in   1   write response
// BEHAVIOUR
// - FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_RDATA, D_WRESP. Reset (async, resetn=0) -> IDLE; all outputs 0; fields, beat counter and starve counter cleared.
// - IDLE: grant = data if data_req, else inst if inst_rd_req. Grant cycle: data_addrok=1 or inst_rd_rdy=1 combinationally, request fields latched -> D_ADDR or I_ADDR next cycle.
// - No accept while busy: addrok/rd_rdy are 0 in every state except IDLE.
// - *_ADDR: mem_req=1 with latched fields, held stable until mem_addr_ok; the mem_addr_ok cycle -> I_DATA, D_RDATA (wr=0) or D_WRESP (wr=1). Earliest mem_req is 1 cycle after grant.
// - I_DATA: inst_ret_valid=mem_rvalid, inst_ret_data=mem_rdata, inst_ret_last=mem_rvalid&mem_rlast (same cycle, 0 latency); beat counter counts beats; on rvalid&rlast -> IDLE.
// - D_RDATA: on mem_rvalid: data_dataok=1, data_rdata=mem_rdata -> IDLE. D_WRESP: on mem_bvalid: data_dataok=1, data_rdata=0 -> IDLE.
// - Back-to-back: IDLE entered on the completion cycle; a new grant happens no earlier than the next cycle (min 1 idle cycle between transactions).
// - Responses outside the matching state (mem_rvalid/mem_bvalid in IDLE/*_ADDR, bvalid during reads) are ignored; nothing is forwarded.
// - Line refill: rlast arriving before LINE_WORDS beats still terminates; beat counter wraps mod LINE_WORDS and is cleared on entry to I_DATA.
// - Both requests in same IDLE cycle: data wins (see CONFIGURATION for override). Loser keeps its req high; it is not latched.
// - Reset mid-transaction: immediate IDLE; downstream is reset by the same resetn and must drop its outstanding transaction.
// CONFIGURATION
// - MEM_ARB_FAIR_EN defined: 8-bit starve counter increments on each data grant while inst_rd_req=1, clears on inst grant or when inst_rd_req=0, saturates at STARVE_LIMIT; when counter==STARVE_LIMIT and both request, inst wins.
// - MEM_ARB_FAIR_EN undefined: strict data priority; counter not instantiated; inst may starve indefinitely.
// TESTING
// - Inst line refill alone, addr 0x1fc00000, type 3'b100, 4 beats A,B,C,D -> mem_len=3, inst_ret_valid x4, inst_ret_last only with D, back to IDLE.
// - Data read 0x80001000 size 2 with mem_addr_ok delayed 3 cycles -> mem_req held 3 cycles with stable fields, one data_dataok with mem_rdata.
// - Data write wstrb 4'b0011 data 0x1234abcd -> mem_wr=1, mem_wstrb=4'b0011, data_dataok only on mem_bvalid, not on mem_addr_ok.
// - Inst and data requests in same cycle -> data_addrok=1, inst_rd_rdy=0; inst granted after data dataok plus one idle cycle.
// - MEM_ARB_FAIR_EN, STARVE_LIMIT=2, data_req held high with inst pending -> grants D,D,I,D,D,I; undefined -> D forever.
// - resetn low during I_DATA after 2 beats -> all outputs 0 immediately; after release next request is granted normally from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one downstream memory port between the icache refill port and the
// data sram port. Only one transaction is in flight at any time. Data requests
// win ties; with MEM_ARB_FAIR_EN defined, a waiting instruction refill is
// guaranteed a grant after STARVE_LIMIT consecutive data grants.
//
// Optional feature macro: MEM_ARB_FAIR_EN (undefined = strict data priority)
//
// Parameters
//   LINE_WORDS    beats per icache line refill (power of two, 2..16)
//   STARVE_LIMIT  data grants tolerated while an inst request waits (1..255)
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   inst_rd_req/type/addr  -> inst_rd_rdy          icache refill request/accept
//   inst_ret_valid/last/data                        refill beats (0 latency)
//   data_req/wr/size/wstrb/addr/wdata -> data_addrok  data request/accept
//   data_dataok, data_rdata                         data completion / read data
//   mem_req/wr/len/size/wstrb/addr/wdata            downstream request
//   mem_addr_ok                                     downstream accept
//   mem_rvalid/rlast/rdata, mem_bvalid              downstream responses
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int LINE_WORDS   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        resetn,
   // icache refill port
   input  logic        inst_rd_req,
   input  logic [2:0]  inst_rd_type,
   input  logic [31:0] inst_rd_addr,
   output logic        inst_rd_rdy,
   output logic        inst_ret_valid,
   output logic        inst_ret_last,
   output logic [31:0] inst_ret_data,
   // data sram port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [2:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addrok,
   output logic        data_dataok,
   output logic [31:0] data_rdata,
   // downstream memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [7:0]  mem_len,
   output logic [2:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_rvalid,
   input  logic        mem_rlast,
   input  logic [31:0] mem_rdata,
   input  logic        mem_bvalid
);

   localparam int BEAT_W = $clog2(LINE_WORDS);

   // Reject illegal configurations at elaboration time.
   if (LINE_WORDS < 2 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 ||
       STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_params
      $error("mem_arbiter: illegal LINE_WORDS or STARVE_LIMIT");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      I_ADDR  = 3'd1,
      I_DATA  = 3'd2,
      D_ADDR  = 3'd3,
      D_RDATA = 3'd4,
      D_WRESP = 3'd5
   } state_t;

   state_t              state;
   logic                wr_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [3:0]          wstrb_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic [BEAT_W-1:0]   beat_cnt;

   logic idle;
   logic inst_pri;
   logic grant_d;
   logic grant_i;
   logic rd_beat;

   // Gating with resetn keeps the accept strobes low while reset is held,
   // even if a requester is already asserting its request.
   assign idle = resetn && (state == IDLE);

`ifdef MEM_ARB_FAIR_EN
   logic [7:0] starve_cnt;

   assign inst_pri = (starve_cnt == 8'(STARVE_LIMIT));

   // Counts data grants made while the refill is waiting; saturates so that
   // the refill keeps priority until it is actually granted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= 8'd0;
      end else if (!inst_rd_req || grant_i) begin
         starve_cnt <= 8'd0;
      end else if (grant_d && !inst_pri) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end
`else
   assign inst_pri = 1'b0;
`endif

   assign grant_i = idle && inst_rd_req && (!data_req || inst_pri);
   assign grant_d = idle && data_req && !grant_i;

   assign data_addrok = grant_d;
   assign inst_rd_rdy = grant_i;

   // Request fields are only presented while a request is outstanding.
   assign mem_req   = (state == I_ADDR) || (state == D_ADDR);
   assign mem_wr    = mem_req && wr_q;
   assign mem_len   = mem_req ? len_q   : 8'd0;
   assign mem_size  = mem_req ? size_q  : 3'd0;
   assign mem_wstrb = mem_req ? wstrb_q : 4'd0;
   assign mem_addr  = mem_req ? addr_q  : 32'd0;
   assign mem_wdata = mem_req ? wdata_q : 32'd0;

   // Responses are forwarded only in the state that expects them.
   assign rd_beat        = (state == I_DATA) && mem_rvalid;
   assign inst_ret_valid = rd_beat;
   assign inst_ret_last  = rd_beat && mem_rlast;
   assign inst_ret_data  = rd_beat ? mem_rdata : 32'd0;

   assign data_dataok = ((state == D_RDATA) && mem_rvalid) ||
                        ((state == D_WRESP) && mem_bvalid);
   assign data_rdata  = ((state == D_RDATA) && mem_rvalid) ? mem_rdata : 32'd0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         wr_q     <= 1'b0;
         len_q    <= 8'd0;
         size_q   <= 3'd0;
         wstrb_q  <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  wr_q    <= data_wr;
                  len_q   <= 8'd0;
                  size_q  <= data_size;
                  wstrb_q <= data_wr ? data_wstrb : 4'd0;
                  addr_q  <= data_addr;
                  wdata_q <= data_wr ? data_wdata : 32'd0;
                  state   <= D_ADDR;
               end else if (grant_i) begin
                  wr_q    <= 1'b0;
                  len_q   <= (inst_rd_type == 3'b100) ? 8'(LINE_WORDS - 1) : 8'd0;
                  size_q  <= 3'd2;
                  wstrb_q <= 4'd0;
                  addr_q  <= inst_rd_addr;
                  wdata_q <= 32'd0;
                  state   <= I_ADDR;
               end
            end
            I_ADDR: begin
               if (mem_addr_ok) begin
                  beat_cnt <= '0;
                  state    <= I_DATA;
               end
            end
            I_DATA: begin
               if (mem_rvalid) begin
                  // Wraps naturally modulo LINE_WORDS; an early rlast still ends the refill.
                  beat_cnt <= beat_cnt + 1'b1;
                  if (mem_rlast) begin
                     state <= IDLE;
                  end
               end
            end
            D_ADDR: begin
               if (mem_addr_ok) begin
                  state <= wr_q ? D_WRESP : D_RDATA;
               end
            end
            D_RDATA: begin
               if (mem_rvalid) begin
                  state <= IDLE;
               end
            end
            D_WRESP: begin
               if (mem_bvalid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_rd_req;
   logic [2:0]  inst_rd_type;
   logic [31:0] inst_rd_addr;
   logic        inst_rd_rdy;
   logic        inst_ret_valid;
   logic        inst_ret_last;
   logic [31:0] inst_ret_data;
   logic        data_req;
   logic        data_wr;
   logic [2:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addrok;
   logic        data_dataok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [7:0]  mem_len;
   logic [2:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_rvalid;
   logic        mem_rlast;
   logic [31:0] mem_rdata;
   logic        mem_bvalid;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   mem_arbiter #(.LINE_WORDS(4), .STARVE_LIMIT(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
      .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
      .inst_ret_data(inst_ret_data),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addrok(data_addrok),
      .data_dataok(data_dataok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_len(mem_len), .mem_size(mem_size),
      .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
      .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] beats [4];
   logic        exp_inst;

   initial begin
      beats[0] = 32'haaaa0001; beats[1] = 32'hbbbb0002;
      beats[2] = 32'hcccc0003; beats[3] = 32'hdddd0004;
      resetn = 1'b0;
      inst_rd_req = 1'b0; inst_rd_type = 3'd0; inst_rd_addr = 32'd0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 3'd0; data_wstrb = 4'd0;
      data_addr = 32'd0; data_wdata = 32'd0;
      mem_addr_ok = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'd0;
      mem_bvalid = 1'b0;

      // ---- reset state: requests held during reset must not be accepted
      step();
      data_req = 1'b1; inst_rd_req = 1'b1;
      #1;
      chk("rst_addrok", data_addrok, 0);
      chk("rst_rdy", inst_rd_rdy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      step();
      data_req = 1'b0; inst_rd_req = 1'b0;
      resetn = 1'b1;
      step();

      // ---- instruction line refill, 4 beats
      inst_rd_req = 1'b1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1fc00000;
      #1;
      chk("i_rdy", inst_rd_rdy, 1);
      chk("i_addrok", data_addrok, 0);
      chk("i_mem_req_grant", mem_req, 0);
      step();
      inst_rd_req = 1'b0;
      #1;
      chk("i_mem_req", mem_req, 1);
      chk("i_mem_addr", mem_addr, 32'h1fc00000);
      chk("i_mem_len", mem_len, 3);
      chk("i_mem_wr", mem_wr, 0);
      chk("i_busy_rdy", inst_rd_rdy, 0);
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0;
      #1;
      chk("i_data_mem_req", mem_req, 0);
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = beats[i]; mem_rlast = (i == 3);
         #1;
         chk("i_ret_valid", inst_ret_valid, 1);
         chk("i_ret_data", inst_ret_data, beats[i]);
         chk("i_ret_last", inst_ret_last, (i == 3));
         step();
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      #1;
      chk("i_done_valid", inst_ret_valid, 0);
      chk("i_done_mem_req", mem_req, 0);
      // stray beat while idle is not forwarded
      mem_rvalid = 1'b1; mem_rdata = 32'h5a5a5a5a;
      #1;
      chk("idle_stray_ret", inst_ret_valid, 0);
      chk("idle_stray_dataok", data_dataok, 0);
      mem_rvalid = 1'b0;
      step();

      // ---- data read, mem_addr_ok delayed 3 cycles
      data_req = 1'b1; data_wr = 1'b0; data_size = 3'd2; data_wstrb = 4'hf;
      data_addr = 32'h80001000;
      #1;
      chk("dr_addrok", data_addrok, 1);
      step();
      data_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("dr_hold_req", mem_req, 1);
         chk("dr_hold_addr", mem_addr, 32'h80001000);
         chk("dr_hold_size", mem_size, 2);
         chk("dr_hold_wstrb", mem_wstrb, 0);
         step();
      end
      mem_addr_ok = 1'b1;
      #1;
      chk("dr_ok_dataok", data_dataok, 0);
      step();
      mem_addr_ok = 1'b0; mem_bvalid = 1'b1;
      #1;
      chk("dr_bvalid_ignored", data_dataok, 0);
      mem_bvalid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hcafef00d;
      #1;
      chk("dr_dataok", data_dataok, 1);
      chk("dr_rdata", data_rdata, 32'hcafef00d);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("dr_done", data_dataok, 0);

      // ---- data write
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_wdata = 32'h1234abcd;
      data_addr = 32'h80002000;
      step();
      data_req = 1'b0;
      #1;
      chk("dw_mem_wr", mem_wr, 1);
      chk("dw_wstrb", mem_wstrb, 4'b0011);
      chk("dw_wdata", mem_wdata, 32'h1234abcd);
      mem_addr_ok = 1'b1;
      #1;
      chk("dw_ok_no_dataok", data_dataok, 0);
      step();
      mem_addr_ok = 1'b0; mem_rvalid = 1'b1;
      #1;
      chk("dw_rvalid_ignored", data_dataok, 0);
      mem_rvalid = 1'b0; mem_bvalid = 1'b1;
      #1;
      chk("dw_dataok", data_dataok, 1);
      chk("dw_rdata", data_rdata, 0);
      step();
      mem_bvalid = 1'b0; data_wr = 1'b0;

      // ---- simultaneous requests: data first, inst after one idle cycle
      data_req = 1'b1; data_addr = 32'h80000040;
      inst_rd_req = 1'b1; inst_rd_type = 3'b000; inst_rd_addr = 32'h1fc00100;
      #1;
      chk("both_addrok", data_addrok, 1);
      chk("both_rdy", inst_rd_rdy, 0);
      step();
      data_req = 1'b0;
      #1;
      chk("both_busy_rdy", inst_rd_rdy, 0);
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000777;
      #1;
      chk("both_dataok", data_dataok, 1);
      chk("both_dataok_rdy", inst_rd_rdy, 0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("both_inst_rdy", inst_rd_rdy, 1);
      step();
      inst_rd_req = 1'b0;
      #1;
      chk("both_inst_len", mem_len, 0);
      chk("both_inst_addr", mem_addr, 32'h1fc00100);
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0; mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = 32'h00000888;
      #1;
      chk("both_inst_last", inst_ret_last, 1);
      step();
      mem_rvalid = 1'b0; mem_rlast = 1'b0;

      // ---- sustained contention: fairness pattern D,D,I or strict D
      data_req = 1'b1; inst_rd_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FAIR_EN
         exp_inst = ((i % 3) == 2);
`else
         exp_inst = 1'b0;
`endif
         #1;
         chk("starve_addrok", data_addrok, !exp_inst);
         chk("starve_rdy", inst_rd_rdy, exp_inst);
         step();
         mem_addr_ok = 1'b1;
         step();
         mem_addr_ok = 1'b0; mem_rvalid = 1'b1; mem_rlast = 1'b1;
         step();
         mem_rvalid = 1'b0; mem_rlast = 1'b0;
      end
      data_req = 1'b0; inst_rd_req = 1'b0;
      step();

      // ---- reset during I_DATA after two beats
      inst_rd_req = 1'b1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1fc00200;
      step();
      inst_rd_req = 1'b0; mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1'b1; mem_rdata = beats[i];
         step();
      end
      #1;
      resetn = 1'b0;
      #1;
      chk("rmid_ret_valid", inst_ret_valid, 0);
      chk("rmid_ret_data", inst_ret_data, 0);
      chk("rmid_mem_req", mem_req, 0);
      chk("rmid_dataok", data_dataok, 0);
      step();
      mem_rvalid = 1'b0;
      resetn = 1'b1;
      step();
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80003000;
      #1;
      chk("post_rst_addrok", data_addrok, 1);
      step();
      data_req = 1'b0;
      #1;
      chk("post_rst_mem_addr", mem_addr, 32'h80003000);
      chk("post_rst_mem_len", mem_len, 0);
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0badf00d;
      #1;
      chk("post_rst_rdata", data_rdata, 32'h0badf00d);
      step();
      mem_rvalid = 1'b0;
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
